ramsey_dma_target: RTL and testbench
====================================

Name: ramsey_dma_target

Overview:
- Synthesizable host-side responder for SDMAC bus-master DMA cycles: bus arbiter (BR/_BG/_BGACK), DMA address counter (ACR) and synchronous cycle terminator (_STERM/_BERR).
- Captures every DMA write (SCSI-to-memory) into a small FIFO and sources deterministic data for DMA reads.
- Used as the memory/Ramsey end of the bus in system-level regression and on the FPGA bring-up board in place of real Ramsey/RAM.

Parameters:
- WAIT_STATES, 4: clocks from sampled _AS low to _STERM assertion (min 1).
- FIFO_DEPTH, 4: capture FIFO entries (power of 2).
- TIMEOUT, 16: clocks a held-off write may wait before _BERR.
- READ_XOR, 32'hA5A5A5A5: read data = ADDR_OUT ^ READ_XOR.

Ports:
- SCLK  in  1  bus clock; all state on rising edge.
- _RST  in  1  async active-low reset.
- BR  in  1  bus request from SDMAC, active high.
- _BG  out  1  bus grant, active low.
- _BGACK  in  1  bus grant acknowledge, active low.
- _AS  in  1  address strobe, active low.
- _DS  in  1  data strobe, active low (monitored only).
- R_W  in  1  1 = read from memory, 0 = write to memory.
- _SIZ1  in  1  low = 16-bit transfer.
- _DMAEN  in  1  low = address generator enabled.
- DATA_IN  in  32  write data from bus.
- DATA_OUT  out  32  read data to bus.
- DATA_OE  out  1  drive DATA_OUT onto bus.
- _STERM  out  1  synchronous termination, active low.
- _BERR  out  1  bus error, active low.
- ACR_WE  in  1  load address counter.
- ACR_D  in  32  address counter load value.
- ADDR_OUT  out  32  current DMA address.
- CAP_VALID  out  1  capture FIFO not empty.
- CAP_READY  in  1  pop capture FIFO.
- CAP_ADDR  out  32  head entry address.
- CAP_DATA  out  32  head entry data.
- CAP_OVF  out  1  sticky: write aborted with _BERR.

Behaviour:
- Reset (async, immediate): _BG=1, _STERM=1, _BERR=1, DATA_OE=0, DATA_OUT=0, ADDR_OUT=0, CAP_VALID=0, CAP_OVF=0, FIFO empty, both FSMs idle.
- Arbiter FSM:
  - A_IDLE: BR=1 & _BGACK=1 & _AS=1 sampled -> A_GRANT; _BG=0 from next cycle.
  - A_GRANT: _BGACK=0 -> A_OWNED, _BG=1. BR=0 first -> A_IDLE, _BG=1.
  - A_OWNED: _BGACK=1 -> A_IDLE.
- Cycle FSM, active only in A_OWNED with _DMAEN=0; otherwise held in C_IDLE:
  - C_IDLE: _AS=0 -> C_WAIT, wait counter=1.
  - C_WAIT: counter increments each clock.
    - Counter reaches WAIT_STATES, and (R_W=1, or FIFO not full) -> C_TERM.
    - Write with FIFO full: stay in C_WAIT. If TIMEOUT clocks then elapse -> C_ERR.
  - C_TERM: _STERM=0 for exactly one clock.
    - Write: push {ADDR_OUT, DATA_IN} into FIFO.
    - Next clock: ADDR_OUT += 2 if _SIZ1=0, else += 4; mod 2^32 wrap. -> C_END.
  - C_ERR: _BERR=0 for one clock; CAP_OVF=1; no push, no increment. -> C_END.
  - C_END: wait for _AS=1 -> C_IDLE.
- Abort: _AS=1 while in C_WAIT -> C_IDLE; no termination, push or increment.
- Read data: DATA_OE=1 in C_WAIT and C_TERM when R_W=1; DATA_OUT = ADDR_OUT ^ READ_XOR, registered on C_IDLE->C_WAIT.
- ACR_WE: loads ADDR_OUT=ACR_D next clock. Coincident with an increment, the load wins and the increment is discarded.
- FIFO:
  - Pop when CAP_VALID & CAP_READY.
  - Push and pop in the same clock on a full FIFO is legal; the write is not held off (full evaluated after pop).
  - CAP_OVF clears only on reset.
- Loss of ownership (_BGACK=1) mid-cycle: cycle FSM -> C_IDLE, strobes negated, no push.

Test Plan:
- Reset, BR=1, _AS=1 -> _BG=0 one clock later; _BGACK=0 -> _BG=1 next clock; _BGACK=1 -> A_IDLE.
- ACR_WE with ACR_D=32'h00000008, then 3 write cycles (_SIZ1=1, DATA_IN 00ABCDEF, 11ABCDEF, 22ABCDEF) -> each _STERM low 1 clock, 4 clocks after _AS low. FIFO holds (8,00ABCDEF), (C,11ABCDEF), (10,22ABCDEF). ADDR_OUT=32'h14.
- Read cycle at ADDR_OUT=32'h20 -> DATA_OE=1, DATA_OUT=32'hA5A5A585; after termination ADDR_OUT=32'h24. Repeat with _SIZ1=0 -> +2.
- CAP_READY=0, 5 writes -> first 4 terminate. Fifth: no _STERM, _BERR low 1 clock after 4+16 clocks, CAP_OVF=1, ADDR_OUT unchanged.
- ACR_D=32'hFFFFFFFC, one write -> ADDR_OUT wraps to 0. ACR_WE coincident with increment -> ADDR_OUT=ACR_D.
- _RST low mid-C_WAIT -> all outputs at reset values immediately. _AS released before WAIT_STATES -> no _STERM, no push.

Source files
------------

// File: rtl/ramsey_dma_target_if.sv
// Bus bundle between the SDMAC-side master and the Ramsey/RAM responder.
// Holds the arbitration, DMA cycle, address-counter and capture-FIFO signals.
interface ramsey_dma_target_if;
    logic        br;
    logic        bg_n;
    logic        bgack_n;
    logic        as_n;
    logic        ds_n;
    logic        r_w;
    logic        siz1_n;
    logic        dmaen_n;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        data_oe;
    logic        sterm_n;
    logic        berr_n;
    logic        acr_we;
    logic [31:0] acr_d;
    logic [31:0] addr_out;
    logic        cap_valid;
    logic        cap_ready;
    logic [31:0] cap_addr;
    logic [31:0] cap_data;
    logic        cap_ovf;

    modport master (
        output br, bgack_n, as_n, ds_n, r_w, siz1_n, dmaen_n, data_in,
               acr_we, acr_d, cap_ready,
        input  bg_n, data_out, data_oe, sterm_n, berr_n, addr_out,
               cap_valid, cap_addr, cap_data, cap_ovf
    );

    modport slave (
        input  br, bgack_n, as_n, ds_n, r_w, siz1_n, dmaen_n, data_in,
               acr_we, acr_d, cap_ready,
        output bg_n, data_out, data_oe, sterm_n, berr_n, addr_out,
               cap_valid, cap_addr, cap_data, cap_ovf
    );
endinterface

// File: rtl/ramsey_dma_target.sv
// Host-side responder for SDMAC bus-master DMA: bus arbiter, DMA address counter,
// synchronous terminator, write-capture FIFO and deterministic read data.
module ramsey_dma_target #(
    parameter int          WAIT_STATES = 4,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          TIMEOUT     = 16,
    parameter logic [31:0] READ_XOR    = 32'hA5A5A5A5
) (
    input logic               i_sclk,
    input logic               i_rst_n,
    ramsey_dma_target_if.slave bus
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam int CW   = $clog2(WAIT_STATES + TIMEOUT + 1);

    typedef enum logic [1:0] {A_IDLE, A_GRANT, A_OWNED} arb_t;
    typedef enum logic [2:0] {C_IDLE, C_WAIT, C_TERM, C_ERR, C_END} cyc_t;

    arb_t            r_arb, w_arb_next;
    cyc_t            r_cyc, w_cyc_next;
    logic [CW-1:0]   r_wcnt, w_wcnt_next;
    logic [31:0]     r_addr;
    logic [31:0]     r_data_out;
    logic            r_ovf;
    logic [PW-1:0]   r_wr, r_rd;
    logic [CNTW-1:0] r_count;
    logic [31:0]     r_mem_addr [FIFO_DEPTH];
    logic [31:0]     r_mem_data [FIFO_DEPTH];

    logic w_active, w_pop, w_full_eff;
    logic w_push, w_inc, w_err_set, w_load_dout;

    assign w_active   = (r_arb == A_OWNED) && !bus.bgack_n && !bus.dmaen_n;
    assign w_pop      = (r_count != '0) && bus.cap_ready;
    // A pop in the same clock frees a slot, so a full FIFO does not hold off the write
    assign w_full_eff = (r_count == CNTW'(FIFO_DEPTH)) && !w_pop;

    always_comb begin
        w_arb_next = r_arb;
        case (r_arb)
            A_IDLE:  if (bus.br && bus.bgack_n && bus.as_n) w_arb_next = A_GRANT;
            A_GRANT: if (!bus.bgack_n) w_arb_next = A_OWNED;
                     else if (!bus.br) w_arb_next = A_IDLE;
            A_OWNED: if (bus.bgack_n) w_arb_next = A_IDLE;
            default: w_arb_next = A_IDLE;
        endcase
    end

    always_comb begin
        w_cyc_next  = r_cyc;
        w_wcnt_next = r_wcnt;
        w_push      = 1'b0;
        w_inc       = 1'b0;
        w_err_set   = 1'b0;
        w_load_dout = 1'b0;
        if (!w_active) begin
            w_cyc_next = C_IDLE;
        end else begin
            case (r_cyc)
                C_IDLE: if (!bus.as_n) begin
                    w_cyc_next  = C_WAIT;
                    w_wcnt_next = CW'(1);
                    w_load_dout = 1'b1;
                end
                C_WAIT: begin
                    if (bus.as_n) begin
                        w_cyc_next = C_IDLE;
                    end else if (r_wcnt >= CW'(WAIT_STATES) && (bus.r_w || !w_full_eff)) begin
                        w_cyc_next = C_TERM;
                    end else if (r_wcnt == CW'(WAIT_STATES + TIMEOUT)) begin
                        w_cyc_next = C_ERR;
                        w_err_set  = 1'b1;
                    end else begin
                        w_wcnt_next = r_wcnt + CW'(1);
                    end
                end
                C_TERM: begin
                    w_cyc_next = C_END;
                    w_inc      = 1'b1;
                    w_push     = !bus.r_w;
                end
                C_ERR:   w_cyc_next = C_END;
                C_END:   if (bus.as_n) w_cyc_next = C_IDLE;
                default: w_cyc_next = C_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_arb      <= A_IDLE;
            r_cyc      <= C_IDLE;
            r_wcnt     <= '0;
            r_addr     <= '0;
            r_data_out <= '0;
            r_ovf      <= 1'b0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
        end else begin
            r_arb  <= w_arb_next;
            r_cyc  <= w_cyc_next;
            r_wcnt <= w_wcnt_next;
            // A counter load beats a coincident post-transfer increment
            if (bus.acr_we)
                r_addr <= bus.acr_d;
            else if (w_inc)
                r_addr <= r_addr + (bus.siz1_n ? 32'd4 : 32'd2);
            if (w_load_dout)
                r_data_out <= r_addr ^ READ_XOR;
            if (w_err_set)
                r_ovf <= 1'b1;
            if (w_push)
                r_wr <= r_wr + PW'(1);
            if (w_pop)
                r_rd <= r_rd + PW'(1);
            r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
        end
    end

    always_ff @(posedge i_sclk) begin
        if (w_push) begin
            r_mem_addr[r_wr] <= r_addr;
            r_mem_data[r_wr] <= bus.data_in;
        end
    end

    assign bus.bg_n      = (r_arb != A_GRANT);
    assign bus.sterm_n   = !(w_active && r_cyc == C_TERM);
    assign bus.berr_n    = !(w_active && r_cyc == C_ERR);
    assign bus.data_oe   = w_active && bus.r_w && (r_cyc == C_WAIT || r_cyc == C_TERM);
    assign bus.data_out  = r_data_out;
    assign bus.addr_out  = r_addr;
    assign bus.cap_valid = (r_count != '0);
    assign bus.cap_addr  = r_mem_addr[r_rd];
    assign bus.cap_data  = r_mem_data[r_rd];
    assign bus.cap_ovf   = r_ovf;
endmodule

// File: tb/tb_ramsey_dma_target.sv
// Directed plus randomized bench for ramsey_dma_target: acts as the SDMAC master
// and checks against a transaction-level model of address, capture queue and overflow.
module tb_ramsey_dma_target;
    localparam int          WS    = 4;
    localparam int          DEPTH = 4;
    localparam int          TO    = 16;
    localparam logic [31:0] RXOR  = 32'hA5A5A5A5;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   errors  = 0;

    logic [31:0] exp_addr = 32'h0;
    logic        exp_ovf  = 1'b0;
    ent_t        exp_q[$];

    ramsey_dma_target_if dif ();

    ramsey_dma_target #(
        .WAIT_STATES(WS), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO), .READ_XOR(RXOR)
    ) dut (
        .i_sclk (clk),
        .i_rst_n(rst_n),
        .bus    (dif.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bg"},    32'(dif.bg_n),      32'd1);
        check({tag, "_sterm"}, 32'(dif.sterm_n),   32'd1);
        check({tag, "_berr"},  32'(dif.berr_n),    32'd1);
        check({tag, "_oe"},    32'(dif.data_oe),   32'd0);
        check({tag, "_dout"},  dif.data_out,       32'd0);
        check({tag, "_addr"},  dif.addr_out,       32'd0);
        check({tag, "_valid"}, 32'(dif.cap_valid), 32'd0);
        check({tag, "_ovf"},   32'(dif.cap_ovf),   32'd0);
    endtask

    task automatic load_acr(input logic [31:0] v);
        dif.acr_we = 1'b1;
        dif.acr_d  = v;
        tick();
        dif.acr_we = 1'b0;
        exp_addr   = v;
        check("acr_load", dif.addr_out, exp_addr);
    endtask

    task automatic acquire();
        dif.br = 1'b1;
        tick();
        check("grant_bg_low", 32'(dif.bg_n), 32'd0);
        dif.bgack_n = 1'b0;
        dif.br      = 1'b0;
        tick();
        check("owned_bg_high", 32'(dif.bg_n), 32'd1);
    endtask

    // One DMA cycle; ld requests an ACR load on the clock that ends termination.
    task automatic bus_cycle(input logic rw, input logic siz, input logic [31:0] wd,
                             input logic ld, input logic [31:0] ldv);
        logic        term_exp;
        int          exp_t;
        int          t;
        logic [31:0] a0;
        ent_t        e;
        a0       = exp_addr;
        term_exp = rw || (exp_q.size() < DEPTH);
        exp_t    = term_exp ? 1 + WS : 1 + WS + TO;
        dif.r_w     = rw;
        dif.siz1_n  = siz;
        dif.data_in = wd;
        dif.as_n    = 1'b0;
        dif.ds_n    = 1'b0;
        t = 0;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (k == 1 && rw) begin
                check("rd_oe_wait", 32'(dif.data_oe), 32'd1);
                check("rd_data", dif.data_out, a0 ^ RXOR);
            end
            if (!dif.sterm_n || !dif.berr_n) begin
                t = k;
                break;
            end
        end
        check("term_tick", 32'(t), 32'(exp_t));
        check("term_kind", {30'd0, dif.sterm_n, dif.berr_n}, term_exp ? 32'd1 : 32'd2);
        if (rw && term_exp)
            check("rd_oe_term", 32'(dif.data_oe), 32'd1);
        if (term_exp) begin
            if (!rw) begin
                e.a = a0;
                e.d = wd;
                exp_q.push_back(e);
            end
            exp_addr = ld ? ldv : a0 + (siz ? 32'd4 : 32'd2);
        end else begin
            exp_ovf = 1'b1;
        end
        if (ld) begin
            dif.acr_we = 1'b1;
            dif.acr_d  = ldv;
        end
        tick();
        dif.acr_we = 1'b0;
        check("strobes_release", {30'd0, dif.sterm_n, dif.berr_n}, 32'd3);
        check("addr_after", dif.addr_out, exp_addr);
        check("ovf_after", 32'(dif.cap_ovf), 32'(exp_ovf));
        dif.as_n = 1'b1;
        dif.ds_n = 1'b1;
        tick();
    endtask

    task automatic drain();
        ent_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cap_valid", 32'(dif.cap_valid), 32'd1);
            check("cap_addr", dif.cap_addr, e.a);
            check("cap_data", dif.cap_data, e.d);
            dif.cap_ready = 1'b1;
            tick();
            dif.cap_ready = 1'b0;
        end
        check("cap_empty", 32'(dif.cap_valid), 32'd0);
    endtask

    initial begin
        logic        rw;
        logic        siz;
        logic [31:0] v;

        rst_n       = 1'b0;
        dif.br      = 1'b0;
        dif.bgack_n = 1'b1;
        dif.as_n    = 1'b1;
        dif.ds_n    = 1'b1;
        dif.r_w     = 1'b1;
        dif.siz1_n  = 1'b1;
        dif.dmaen_n = 1'b1;
        dif.data_in = '0;
        dif.acr_we  = 1'b0;
        dif.acr_d   = '0;
        dif.cap_ready = 1'b0;
        repeat (2) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Arbitration handshake, release, then re-acquire for the data tests
        acquire();
        dif.bgack_n = 1'b1;
        tick();
        check("release_bg", 32'(dif.bg_n), 32'd1);
        acquire();
        dif.dmaen_n = 1'b0;

        // Three 32-bit writes from address 8
        load_acr(32'h0000_0008);
        bus_cycle(1'b0, 1'b1, 32'h00AB_CDEF, 1'b0, 32'h0);
        bus_cycle(1'b0, 1'b1, 32'h11AB_CDEF, 1'b0, 32'h0);
        bus_cycle(1'b0, 1'b1, 32'h22AB_CDEF, 1'b0, 32'h0);
        check("addr_after_3wr", dif.addr_out, 32'h0000_0014);
        drain();

        // Reads, 32-bit then 16-bit
        load_acr(32'h0000_0020);
        bus_cycle(1'b1, 1'b1, 32'h0, 1'b0, 32'h0);
        check("addr_rd32", dif.addr_out, 32'h0000_0024);
        bus_cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("addr_rd16", dif.addr_out, 32'h0000_0026);

        // Randomized mix of reads/writes and sizes
        for (int i = 0; i < 8; i++) begin
            if (i % 3 == 0)
                load_acr($urandom & 32'hFFFF_FFFE);
            rw  = 1'($urandom_range(0, 1));
            siz = 1'($urandom_range(0, 1));
            v   = $urandom;
            bus_cycle(rw, siz, v, 1'b0, 32'h0);
            drain();
        end

        // Fill the FIFO, then a held-off write times out with bus error
        load_acr(32'h0000_1000);
        for (int i = 0; i < DEPTH + 1; i++)
            bus_cycle(1'b0, 1'b1, $urandom, 1'b0, 32'h0);
        check("ovf_sticky", 32'(dif.cap_ovf), 32'd1);
        check("addr_no_inc_on_err", dif.addr_out, 32'h0000_1010);
        drain();

        // Address wrap, then a load coinciding with the increment
        load_acr(32'hFFFF_FFFC);
        bus_cycle(1'b0, 1'b1, $urandom, 1'b0, 32'h0);
        check("addr_wrap", dif.addr_out, 32'h0000_0000);
        v = $urandom & 32'hFFFF_FFF0;
        bus_cycle(1'b0, 1'b0, $urandom, 1'b1, v);
        check("load_beats_inc", dif.addr_out, v);
        drain();

        // Abort before wait states elapse: no termination, push or increment
        dif.r_w  = 1'b0;
        dif.as_n = 1'b0;
        repeat (WS - 2) begin
            tick();
            check("abort_no_sterm", 32'(dif.sterm_n), 32'd1);
        end
        dif.as_n = 1'b1;
        repeat (WS + 2) tick();
        check("abort_sterm", 32'(dif.sterm_n), 32'd1);
        check("abort_addr", dif.addr_out, exp_addr);
        check("abort_no_push", 32'(dif.cap_valid), 32'd0);

        // Leave an entry in the FIFO, then reset in the middle of a wait
        bus_cycle(1'b0, 1'b1, $urandom, 1'b0, 32'h0);
        check("pre_reset_valid", 32'(dif.cap_valid), 32'd1);
        dif.as_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        dif.as_n = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
